// File: rtl/accel_stream_ctrl.sv
// Stream sequencer: fetches a message from local RAM over port A, feeds it to a
// streaming hash core in CORE_WIDTH words, and writes the digest back over port B.
module accel_stream_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CORE_WIDTH = 64,
    parameter int LEN_WIDTH  = 16,
    parameter int OUT_WORDS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [LEN_WIDTH-1:0]    in_len,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err,
    output logic [2:0]              state_o,
    output logic                    mem_en_a,
    output logic                    mem_we_a,
    output logic [ADDR_WIDTH-1:0]   mem_addr_a,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_a,
    output logic                    mem_en_b,
    output logic                    mem_we_b,
    output logic [ADDR_WIDTH-1:0]   mem_addr_b,
    output logic [DATA_WIDTH-1:0]   mem_wdata_b,
    output logic [DATA_WIDTH/8-1:0] mem_be_b,
    output logic                    core_start,
    output logic [CORE_WIDTH-1:0]   core_din,
    output logic                    core_din_valid,
    input  logic                    core_buffer_full,
    output logic                    core_last_block,
    input  logic                    core_ready,
    input  logic [CORE_WIDTH-1:0]   core_dout,
    input  logic                    core_dout_valid
);

    localparam int RATIO  = CORE_WIDTH / DATA_WIDTH;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int ISS_W  = $clog2(RATIO + 1);
    localparam int OUT_W  = $clog2(OUT_WORDS + 1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    word_cnt_q, word_cnt_d;
    logic [ISS_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic                    rvalid_q, rvalid_d;
    logic [BEAT_W-1:0]       cap_idx_q, cap_idx_d;
    logic [CORE_WIDTH-1:0]   din_q, din_d;
    logic                    core_start_q, core_start_d;
    logic [1:0]              err_q, err_d;
    logic [BEAT_W-1:0]       beat_b_q, beat_b_d;
    logic [OUT_W-1:0]        out_cnt_q, out_cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    skid_wp_q, skid_wp_d;
    logic                    skid_rp_q, skid_rp_d;
    logic [1:0]              skid_cnt_q, skid_cnt_d;
    logic [CORE_WIDTH-1:0]   skid_q [2];
    logic [CORE_WIDTH-1:0]   skid_d [2];
    logic [1:0]              skid_we;
    logic                    push, pop, ovf_now, last_word;
    logic [CORE_WIDTH-1:0]   head;
    logic [DATA_WIDTH-1:0]   head_beats [RATIO];

    // core_ready is informational only; sequencing relies on dout strobes.
    logic unused_core_ready;
    assign unused_core_ready = core_ready;

    assign last_word = (word_cnt_q == (len_q - LEN_WIDTH'(1)));
    assign head      = skid_q[skid_rp_q];

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_beat
        assign din_d[gi*DATA_WIDTH +: DATA_WIDTH] =
            (rvalid_q && cap_idx_q == BEAT_W'(gi)) ? mem_rdata_a
                                                   : din_q[gi*DATA_WIDTH +: DATA_WIDTH];
        assign head_beats[gi] = head[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_skid
        assign skid_d[gi] = skid_we[gi] ? core_dout : skid_q[gi];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) skid_q[gi] <= '0;
            else     skid_q[gi] <= skid_d[gi];
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_a_d       = addr_a_q;
        addr_b_d       = addr_b_q;
        len_d          = len_q;
        word_cnt_d     = word_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        rvalid_d       = 1'b0;
        cap_idx_d      = cap_idx_q;
        core_start_d   = 1'b0;
        err_d          = err_q;
        beat_b_d       = beat_b_q;
        out_cnt_d      = out_cnt_q;
        ovf_d          = ovf_q;
        skid_wp_d      = skid_wp_q;
        skid_rp_d      = skid_rp_q;
        skid_cnt_d     = skid_cnt_q;
        skid_we        = 2'b00;
        push           = 1'b0;
        pop            = 1'b0;
        ovf_now        = 1'b0;
        mem_en_a       = 1'b0;
        mem_en_b       = 1'b0;
        core_din_valid = 1'b0;
        core_last_block = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_a_d   = src_addr;
                    addr_b_d   = dst_addr;
                    len_d      = in_len;
                    err_d      = 2'd0;
                    word_cnt_d = '0;
                    rd_cnt_d   = '0;
                    cap_idx_d  = '0;
                    beat_b_d   = '0;
                    out_cnt_d  = '0;
                    ovf_d      = 1'b0;
                    skid_wp_d  = 1'b0;
                    skid_rp_d  = 1'b0;
                    skid_cnt_d = 2'd0;
                    if (in_len == '0) begin
                        err_d   = 2'd1;
                        state_d = S_DONE;
                    end else begin
                        core_start_d = 1'b1;
                        state_d      = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (rd_cnt_q != ISS_W'(RATIO)) begin
                    mem_en_a = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    addr_a_d = addr_a_q + STEP;
                    rvalid_d = 1'b1;
                end
                // Read data trails the issue by one cycle; the last capture ends the fetch.
                if (rvalid_q) begin
                    if (cap_idx_q == BEAT_W'(RATIO - 1)) begin
                        cap_idx_d = '0;
                        rd_cnt_d  = '0;
                        state_d   = S_FEED;
                    end else begin
                        cap_idx_d = cap_idx_q + 1'b1;
                    end
                end
            end
            S_FEED: begin
                core_last_block = last_word;
                if (!core_buffer_full) begin
                    core_din_valid = 1'b1;
                    if (last_word) begin
                        state_d = S_WAIT;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WAIT: begin
                if (core_dout_valid) begin
                    push    = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (skid_cnt_q != 2'd0) begin
                    mem_en_b = 1'b1;
                    addr_b_d = addr_b_q + STEP;
                    if (beat_b_q == BEAT_W'(RATIO - 1)) begin
                        beat_b_d = '0;
                        pop      = 1'b1;
                    end else begin
                        beat_b_d = beat_b_q + 1'b1;
                    end
                end
                // A full buffer refuses the new word even if the head retires this cycle.
                if (core_dout_valid) begin
                    if (skid_cnt_q == 2'd2) begin
                        ovf_now = 1'b1;
                        ovf_d   = 1'b1;
                        err_d   = 2'd2;
                    end else begin
                        push = 1'b1;
                    end
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (ovf_q || ovf_now || out_cnt_q == OUT_W'(OUT_WORDS - 1))
                        state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            skid_we[skid_wp_q] = 1'b1;
            skid_wp_d          = ~skid_wp_q;
        end
        if (pop) skid_rp_d = ~skid_rp_q;
        if (push && !pop)      skid_cnt_d = skid_cnt_q + 2'd1;
        else if (pop && !push) skid_cnt_d = skid_cnt_q - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            rvalid_q     <= 1'b0;
            cap_idx_q    <= '0;
            din_q        <= '0;
            core_start_q <= 1'b0;
            err_q        <= 2'd0;
            beat_b_q     <= '0;
            out_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            skid_wp_q    <= 1'b0;
            skid_rp_q    <= 1'b0;
            skid_cnt_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rvalid_q     <= rvalid_d;
            cap_idx_q    <= cap_idx_d;
            din_q        <= din_d;
            core_start_q <= core_start_d;
            err_q        <= err_d;
            beat_b_q     <= beat_b_d;
            out_cnt_q    <= out_cnt_d;
            ovf_q        <= ovf_d;
            skid_wp_q    <= skid_wp_d;
            skid_rp_q    <= skid_rp_d;
            skid_cnt_q   <= skid_cnt_d;
        end
    end

    assign busy        = (state_q == S_FETCH) || (state_q == S_FEED) ||
                         (state_q == S_WAIT)  || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign state_o     = state_q;
    assign mem_we_a    = 1'b0;
    assign mem_addr_a  = addr_a_q;
    assign mem_we_b    = mem_en_b;
    assign mem_addr_b  = addr_b_q;
    assign mem_wdata_b = mem_en_b ? head_beats[beat_b_q] : '0;
    assign mem_be_b    = {(DATA_WIDTH/8){mem_en_b}};
    assign core_start  = core_start_q;
    assign core_din    = din_q;

endmodule
